// File: rtl/iq_sweep_averager.sv
// Multi-channel frequency sweep and averaging engine with a FWFT result FIFO.
// Optional accumulator saturation is enabled by defining IQ_SWEEP_SATURATE_EN.
module iq_sweep_averager #(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned INBITS    = 24,
  parameter int unsigned SUMBITS   = 62,
  parameter int unsigned PHASEBITS = 32,
  parameter int unsigned FIFO_AW   = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [CHANNELS*INBITS-1:0]    quad_i,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic [PHASEBITS-1:0]          cfg_phase_start_i,
  input  logic [PHASEBITS-1:0]          cfg_phase_step_i,
  input  logic [15:0]                   cfg_points_i,
  input  logic [31:0]                   cfg_averages_i,
  input  logic [31:0]                   cfg_sleep_i,
  output logic [PHASEBITS-1:0]          phase_inc_o,
  output logic                          phase_upd_o,
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic [CHANNELS*SUMBITS-1:0]   res_data_o,
  output logic [15:0]                   res_index_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          sat_o
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned DATAW = CHANNELS * SUMBITS;
  localparam int unsigned WORDW = 16 + DATAW;
  localparam int unsigned CNTW  = FIFO_AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACCUM, S_PUSH} state_t;

  state_t                      r_state;
  logic [PHASEBITS-1:0]        r_phase;
  logic [PHASEBITS-1:0]        r_step;
  logic                        r_upd;
  logic                        r_done0;
  logic [15:0]                 r_idx;
  logic [15:0]                 r_points;
  logic [31:0]                 r_avg;
  logic [31:0]                 r_sleep;
  logic [31:0]                 r_cnt;
  logic signed [SUMBITS-1:0]   r_sum [CHANNELS];
  logic [WORDW-1:0]            r_mem [DEPTH];
  logic [FIFO_AW-1:0]          r_wptr;
  logic [FIFO_AW-1:0]          r_rptr;
  logic [CNTW-1:0]             r_count;

  logic signed [SUMBITS-1:0]   w_sum_nxt [CHANNELS];
  logic [DATAW-1:0]            w_pack;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_last;

`ifdef IQ_SWEEP_SATURATE_EN
  logic                        r_sat;
  logic                        w_clip;
`endif

  assign w_full  = (r_count == CNTW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && res_ready_i;
  assign w_push  = (r_state == S_PUSH) && !w_full && !abort_i;
  assign w_last  = (r_idx == r_points - 16'd1);

  // Per-channel next sum: sign-extended sample added, optionally clamped on overflow.
  always_comb begin
    logic signed [SUMBITS-1:0] ext;
`ifdef IQ_SWEEP_SATURATE_EN
    logic signed [SUMBITS:0]   wide;
    w_clip = 1'b0;
`endif
    w_pack = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      ext = {{(SUMBITS-INBITS){quad_i[k*INBITS+INBITS-1]}}, quad_i[k*INBITS +: INBITS]};
`ifdef IQ_SWEEP_SATURATE_EN
      wide = {r_sum[k][SUMBITS-1], r_sum[k]} + {ext[SUMBITS-1], ext};
      if (wide[SUMBITS] != wide[SUMBITS-1]) begin
        w_clip       = 1'b1;
        w_sum_nxt[k] = wide[SUMBITS] ? {1'b1, {(SUMBITS-1){1'b0}}} : {1'b0, {(SUMBITS-1){1'b1}}};
      end else begin
        w_sum_nxt[k] = wide[SUMBITS-1:0];
      end
`else
      w_sum_nxt[k] = r_sum[k] + ext;
`endif
      w_pack[k*SUMBITS +: SUMBITS] = r_sum[k];
    end
  end

  // Sweep sequencer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_phase  <= '0;
      r_step   <= '0;
      r_upd    <= 1'b0;
      r_done0  <= 1'b0;
      r_idx    <= '0;
      r_points <= '0;
      r_avg    <= '0;
      r_sleep  <= '0;
      r_cnt    <= '0;
      for (int k = 0; k < CHANNELS; k++) r_sum[k] <= '0;
`ifdef IQ_SWEEP_SATURATE_EN
      r_sat    <= 1'b0;
`endif
    end else begin
      r_upd   <= 1'b0;
      r_done0 <= 1'b0;
      if (abort_i) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start_i) begin
              r_step   <= cfg_phase_step_i;
              r_points <= cfg_points_i;
              r_avg    <= cfg_averages_i;
              r_sleep  <= cfg_sleep_i;
              r_idx    <= '0;
`ifdef IQ_SWEEP_SATURATE_EN
              r_sat    <= 1'b0;
`endif
              if (cfg_points_i == 16'd0) begin
                r_done0 <= 1'b1;
              end else begin
                r_phase <= cfg_phase_start_i;
                r_upd   <= 1'b1;
                r_cnt   <= cfg_sleep_i;
                r_state <= S_SETTLE;
              end
            end
          end
          S_SETTLE: begin
            if (r_cnt == 32'd0) begin
              for (int k = 0; k < CHANNELS; k++) r_sum[k] <= '0;
              r_cnt   <= r_avg;
              r_state <= (r_avg == 32'd0) ? S_PUSH : S_ACCUM;
            end else begin
              r_cnt <= r_cnt - 32'd1;
            end
          end
          S_ACCUM: begin
            for (int k = 0; k < CHANNELS; k++) r_sum[k] <= w_sum_nxt[k];
`ifdef IQ_SWEEP_SATURATE_EN
            if (w_clip) r_sat <= 1'b1;
`endif
            if (r_cnt == 32'd1) r_state <= S_PUSH;
            else                r_cnt   <= r_cnt - 32'd1;
          end
          S_PUSH: begin
            if (!w_full) begin
              if (w_last) begin
                r_state <= S_IDLE;
              end else begin
                r_idx   <= r_idx + 16'd1;
                r_phase <= r_phase + r_step;
                r_upd   <= 1'b1;
                r_cnt   <= r_sleep;
                r_state <= S_SETTLE;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Result FIFO storage; pointers alone define validity, so no reset is needed here.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= {r_idx, w_pack};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + FIFO_AW'(1);
      if (w_pop)  r_rptr <= r_rptr + FIFO_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign phase_inc_o = r_phase;
  assign phase_upd_o = r_upd;
  assign res_valid_o = !w_empty;
  assign res_data_o  = w_empty ? '0 : r_mem[r_rptr][DATAW-1:0];
  assign res_index_o = w_empty ? '0 : r_mem[r_rptr][WORDW-1 -: 16];
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = r_done0 | (w_push & w_last);
`ifdef IQ_SWEEP_SATURATE_EN
  assign sat_o       = r_sat;
`else
  assign sat_o       = 1'b0;
`endif

endmodule

// File: tb/tb_iq_sweep_averager.sv
// Scoreboard bench for iq_sweep_averager: sweep timing, backpressure, abort,
// degenerate configs, reset mid-sweep and accumulator overflow behaviour.
module tb_iq_sweep_averager;

  localparam int unsigned SB = 62;

  typedef struct packed {
    logic [15:0]     idx;
    logic [2*SB-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  // Main DUT: two channels, four-deep FIFO.
  logic [47:0]    quad_i = '0;
  logic           start_i = 1'b0, abort_i = 1'b0, res_ready_i = 1'b0;
  logic [31:0]    cfg_phase_start_i = '0, cfg_phase_step_i = '0;
  logic [15:0]    cfg_points_i = '0;
  logic [31:0]    cfg_averages_i = '0, cfg_sleep_i = '0;
  logic [31:0]    phase_inc_o;
  logic           phase_upd_o, res_valid_o, busy_o, done_o, sat_o;
  logic [2*SB-1:0] res_data_o;
  logic [15:0]    res_index_o;

  iq_sweep_averager #(.CHANNELS(2), .INBITS(24), .SUMBITS(SB), .PHASEBITS(32), .FIFO_AW(2)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .quad_i(quad_i), .start_i(start_i), .abort_i(abort_i),
    .cfg_phase_start_i(cfg_phase_start_i), .cfg_phase_step_i(cfg_phase_step_i),
    .cfg_points_i(cfg_points_i), .cfg_averages_i(cfg_averages_i), .cfg_sleep_i(cfg_sleep_i),
    .phase_inc_o(phase_inc_o), .phase_upd_o(phase_upd_o), .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i), .res_data_o(res_data_o), .res_index_o(res_index_o),
    .busy_o(busy_o), .done_o(done_o), .sat_o(sat_o));

  // Narrow-accumulator DUT for overflow behaviour.
  logic [23:0] s_quad = 24'h7FFFFF;
  logic        s_start = 1'b0, s_ready = 1'b0;
  logic [31:0] s_phase;
  logic        s_upd, s_valid, s_busy, s_done, s_sat;
  logic [25:0] s_data;
  logic [15:0] s_index;

  iq_sweep_averager #(.CHANNELS(1), .INBITS(24), .SUMBITS(26), .PHASEBITS(32), .FIFO_AW(2)) u_sat (
    .clk_i(clk), .rst_i(rst_i), .quad_i(s_quad), .start_i(s_start), .abort_i(1'b0),
    .cfg_phase_start_i(32'd5), .cfg_phase_step_i(32'd1),
    .cfg_points_i(16'd1), .cfg_averages_i(32'd8), .cfg_sleep_i(32'd0),
    .phase_inc_o(s_phase), .phase_upd_o(s_upd), .res_valid_o(s_valid),
    .res_ready_i(s_ready), .res_data_o(s_data), .res_index_o(s_index),
    .busy_o(s_busy), .done_o(s_done), .sat_o(s_sat));

  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;
  int n_done = 0;
  exp_t sb[$];
  logic [31:0] ph_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input int i, input longint s0, input longint s1);
    exp_t e;
    e.idx  = 16'(i);
    e.data = {SB'(s1), SB'(s0)};
    return e;
  endfunction

  // Output monitor: every accepted word is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (phase_upd_o) ph_q.push_back(phase_inc_o);
      if (done_o) n_done++;
      if (res_valid_o && res_ready_i) begin
        if (sb.size() == 0) begin
          check("unexpected_word", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("res_index", res_index_o, e.idx);
          check("res_data", res_data_o, e.data);
          n_pop++;
        end
      end
    end
  end

  // Programs a sweep, queues the words it should produce, and pulses start.
  task automatic go(input int ps, input int st, input int pts, input int avg, input int slp,
                    input int q0, input int q1, input int n_exp);
    quad_i            = {24'(q1), 24'(q0)};
    cfg_phase_start_i = 32'(ps);
    cfg_phase_step_i  = 32'(st);
    cfg_points_i      = 16'(pts);
    cfg_averages_i    = 32'(avg);
    cfg_sleep_i       = 32'(slp);
    for (int i = 0; i < n_exp; i++) sb.push_back(mk(i, longint'(avg) * q0, longint'(avg) * q1));
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int exp_c, input int limit);
    int c;
    bit found;
    c = 0;
    found = 1'b0;
    while (!found && c < limit) begin
      @(negedge clk);
      c++;
      if (done_o) found = 1'b1;
    end
    check("done_seen", found, 1'b1);
    if (exp_c > 0) check("done_cycle", c, exp_c);
  endtask

  task automatic wait_drain(input int limit);
    int c;
    c = 0;
    while ((sb.size() != 0 || res_valid_o) && c < limit) begin
      @(negedge clk);
      c++;
    end
    check("drained", (sb.size() == 0) && !res_valid_o, 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_phase"}, phase_inc_o, 32'd0);
    check({tag, "_upd"},   phase_upd_o, 1'b0);
    check({tag, "_valid"}, res_valid_o, 1'b0);
    check({tag, "_data"},  res_data_o, '0);
    check({tag, "_index"}, res_index_o, 16'd0);
    check({tag, "_busy"},  busy_o, 1'b0);
    check({tag, "_done"},  done_o, 1'b0);
    check({tag, "_sat"},   sat_o, 1'b0);
  endtask

  initial begin
    int d0, p0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check_reset_vals("rst");
    check("sat_dut_rst", s_sat, 1'b0);

    // Basic three-point sweep with phase sequence and done timing.
    res_ready_i = 1'b1;
    ph_q.delete();
    go(1000, 10, 3, 4, 2, 100, -3, 3);
    wait_done(24, 60);
    @(negedge clk);
    check("busy_after_done", busy_o, 1'b0);
    wait_drain(20);
    check("phase_pulses", ph_q.size(), 3);
    for (int i = 0; i < ph_q.size() && i < 3; i++) check("phase_seq", ph_q[i], 32'(1000 + 10 * i));

    // Backpressure: four words buffered, engine stalls in PUSH.
    res_ready_i = 1'b0;
    p0 = n_pop;
    d0 = n_done;
    go(500, 3, 6, 2, 1, 7, -1000, 6);
    repeat (60) @(negedge clk);
    check("stall_busy", busy_o, 1'b1);
    check("stall_valid", res_valid_o, 1'b1);
    check("stall_head_idx", res_index_o, 16'd0);
    check("stall_phase", phase_inc_o, 32'd512);
    check("stall_no_done", n_done - d0, 0);
    @(posedge clk); #1 res_ready_i = 1'b1;
    wait_done(-1, 200);
    wait_drain(30);
    check("bp_pops", n_pop - p0, 6);

    // Abort during ACCUM of point 1.
    p0 = n_pop;
    d0 = n_done;
    go(1000, 10, 3, 4, 2, 100, -3, 1);
    repeat (12) @(negedge clk);
    @(posedge clk); #1 abort_i = 1'b1;
    @(posedge clk); #1 abort_i = 1'b0;
    @(negedge clk);
    check("abort_idle", busy_o, 1'b0);
    check("abort_phase_hold", phase_inc_o, 32'd1010);
    repeat (30) @(negedge clk);
    check("abort_no_done", n_done - d0, 0);
    wait_drain(10);
    check("abort_pops", n_pop - p0, 1);
    go(1000, 10, 3, 4, 2, 100, -3, 3);
    wait_done(24, 60);
    wait_drain(20);

    // Zero points: immediate done, never busy.
    go(0, 0, 0, 4, 2, 1, 1, 0);
    @(negedge clk);
    check("pts0_done", done_o, 1'b1);
    check("pts0_busy", busy_o, 1'b0);
    @(negedge clk);
    check("pts0_done_clr", done_o, 1'b0);
    check("pts0_busy2", busy_o, 1'b0);

    // Zero averages: single word of zero sums.
    go(0, 0, 1, 0, 2, 555, -555, 1);
    wait_done(4, 20);
    wait_drain(10);

    // Reset mid-SETTLE with a word still buffered.
    res_ready_i = 1'b0;
    go(0, 0, 1, 1, 0, 100, -3, 1);
    wait_done(-1, 20);
    @(negedge clk);
    check("pre_rst_valid", res_valid_o, 1'b1);
    go(7, 1, 2, 4, 20, 100, -3, 0);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rst_i = 1'b1;
    sb.delete();
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    res_ready_i = 1'b1;
    go(1000, 10, 3, 4, 2, 100, -3, 3);
    wait_done(24, 60);
    wait_drain(20);

    // Narrow accumulator: clamp or wrap depending on build.
    s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    begin
      int c;
      c = 0;
      while (!s_done && c < 50) begin
        @(negedge clk);
        c++;
      end
      check("sat_done_seen", s_done, 1'b1);
    end
    @(negedge clk);
    check("sat_valid", s_valid, 1'b1);
`ifdef IQ_SWEEP_SATURATE_EN
    check("sat_sum", s_data, 26'h1FFFFFF);
    check("sat_flag", s_sat, 1'b1);
`else
    check("wrap_sum", s_data, 26'h3FFFFF8);
    check("wrap_flag", s_sat, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iq_sweep_averager.md
# iq_sweep_averager

Parametrised multi-channel sweep-and-average engine for the IQ demodulator chain. It steps an fgen phase-increment word through a programmed list of frequency points. At each point it waits a settling time, then accumulates N samples of every demodulated quadrature channel. Each point's sums are pushed into a result FIFO for the PS readout logic. It generalises single-point, two-channel network-analyser averaging to CHANNELS channels, multi-point autonomous sweeps and buffered results with backpressure.

## Interface
- CHANNELS, 2, number of quadrature channels averaged in parallel (1..8)
- INBITS, 24, signed width of each input quadrature
- SUMBITS, 62, signed width of each accumulator (must be ≥ INBITS+1)
- PHASEBITS, 32, width of the fgen phase-increment word
- FIFO_AW, 4, log2 of result FIFO depth
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active high
- quad_i  in  CHANNELS*INBITS  packed signed quadratures, channel 0 in LSBs
- start_i  in  1  start-sweep pulse
- abort_i  in  1  abort-sweep pulse
- cfg_phase_start_i  in  PHASEBITS  first phase increment
- cfg_phase_step_i  in  PHASEBITS  increment added per point (modulo 2^PHASEBITS)
- cfg_points_i  in  16  number of points
- cfg_averages_i  in  32  samples summed per point
- cfg_sleep_i  in  32  settling cycles per point
- phase_inc_o  out  PHASEBITS  current phase increment to fgen
- phase_upd_o  out  1  one-cycle pulse when phase_inc_o changes
- res_valid_o  out  1  FIFO not empty
- res_ready_i  in  1  consumer accepts head word
- res_data_o  out  CHANNELS*SUMBITS  packed sums of head word
- res_index_o  out  16  point index of head word
- busy_o  out  1  state ≠ IDLE
- done_o  out  1  one-cycle pulse at sweep completion
- sat_o  out  1  sticky accumulator-saturation flag

## Operation
- States: IDLE, SETTLE, ACCUM, PUSH.
- IDLE, start_i=1:
  - latch all cfg_* inputs; changes during the sweep are ignored
  - clear sat_o and the point index
  - if points=0: pulse done_o and stay in IDLE
  - otherwise: load phase_inc_o=phase_start, pulse phase_upd_o, enter SETTLE
- start_i outside IDLE is ignored.
- SETTLE: load the counter with sleep on entry; decrement each cycle; go to ACCUM in the cycle the counter reads 0. SETTLE therefore lasts sleep+1 cycles.
- ACCUM:
  - clear the sums on entry
  - each cycle, add the sign-extended quad_i channel k to sum k, for exactly `averages` cycles, then go to PUSH
  - averages=0 skips ACCUM; the pushed sums are 0
- PUSH, FIFO not full:
  - write {index, sums}
  - if index=points-1: pulse done_o, go to IDLE
  - else: index+1, phase_inc_o += step, pulse phase_upd_o, go to SETTLE
- PUSH, FIFO full: stall in PUSH with sums held and quad_i ignored.
- abort_i (any state, takes priority over all other transitions): go to IDLE next cycle; no push, no done_o; FIFO contents are kept; phase_inc_o holds its value.
- FIFO:
  - first-word-fall-through
  - pop on res_valid_o & res_ready_i
  - push is decided on the registered full flag, so a simultaneous pop does not free a slot that cycle
  - push and pop in the same cycle while not full/empty: count unchanged
  - pointers wrap modulo 2^FIFO_AW
  - rst_i empties the FIFO; abort_i does not
- Reset values: phase_inc_o=0, phase_upd_o=0, res_valid_o=0, res_data_o=0, res_index_o=0, busy_o=0, done_o=0, sat_o=0, state=IDLE.
- Reset mid-sweep: same reset values, no partial push.

## Timing
- start_i in cycle t → phase_upd_o and SETTLE in t+1.
- Cycles per unstalled point: (sleep+1) + averages + 1.
- quad_i is registered in the first ACCUM cycle and in each following ACCUM cycle.
- A pushed word is visible on res_valid_o/res_data_o one cycle after PUSH.
- done_o is asserted in the same cycle as the final PUSH write; busy_o falls in the next cycle.

## Configuration
- IQ_SWEEP_SATURATE_EN defined:
  - each accumulator clamps to ±(2^(SUMBITS-1)) bounds: max 2^(SUMBITS-1)-1, min -2^(SUMBITS-1)
  - any clamp sets sat_o until the next accepted start_i or rst_i
- Undefined: sums wrap modulo 2^SUMBITS; sat_o is tied to 0.

## Test plan
- CHANNELS=2; start=1000, step=10, points=3, sleep=2, averages=4; quad ch0=100, ch1=-3; ready=1
  → three words, index 0/1/2, sums 400/-12
  → phase_inc_o = 1000, 1010, 1020 with one phase_upd_o pulse each
  → done_o pulses 24 cycles after start_i.
- ready=0, FIFO_AW=2, points=6 → four words buffered; engine stalls in PUSH with busy_o=1; asserting ready drains all 6 words in order with no loss.
- abort_i during ACCUM of point 1 → IDLE next cycle; only the point-0 word is in the FIFO; no done_o; a new start_i works normally.
- points=0 → done_o one cycle after start_i; busy_o never asserted. averages=0, points=1 → one word with zero sums.
- SUMBITS=26, INBITS=24, quad=2^23-1, averages=8: with the macro → sums=2^25-1 and sat_o=1; without → wrapped value and sat_o=0.
- rst_i mid-SETTLE → all outputs at their reset values next cycle; FIFO empty; start_i accepted afterwards.
